req_issuer4: RTL and testbench

Requester-side agent for the 4-way fixed-priority grant selector (`ps4`: `req[3:0]`, `en`, `gnt[3:0]`, highest index wins). It buffers per-channel request events as pending counts, drives `req`/`en` toward the selector, and consumes `gnt` to retire requests, emitting completion pulses. It also flags starvation caused by fixed priority and any grant that violates the protocol. It sits between the four client channels and the selector instance.

---
 rtl/req_issuer4_pkg.sv | 23 ++
 rtl/req_issuer4_if.sv | 27 ++
 rtl/req_issuer4_chan.sv | 65 ++++++
 rtl/req_issuer4.sv | 63 ++++++
 tb/tb_req_issuer4.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/req_issuer4_pkg.sv
// Shared constants, counter types and helpers for the 4-channel request issuer.
// Channel count is fixed by the fixed-priority selector this block feeds.
package req_issuer_pkg;

    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned STARVE_LIM = 8;
    localparam int unsigned WAIT_W     = $clog2(STARVE_LIM + 1);

    typedef logic [CNT_W-1:0]  pend_t;
    typedef logic [WAIT_W-1:0] wait_t;

    localparam pend_t PEND_MAX = '1;
    localparam wait_t WAIT_MAX = wait_t'(STARVE_LIM);

    // True when at most one bit of the grant vector is set.
    function automatic logic at_most_one(logic [NUM_REQ-1:0] v);
        logic [NUM_REQ-1:0] v_dec;
        v_dec = v - {{(NUM_REQ-1){1'b0}}, 1'b1};
        return (v & v_dec) == '0;
    endfunction

endpackage

// File: rtl/req_issuer4_if.sv
// Handshake bundle between the client-side issuer and the priority selector.
// slave is the issuer's view; master is the environment (clients + selector).
interface req_issuer4_if;
    import req_issuer_pkg::*;

    logic [NUM_REQ-1:0] push;
    logic               hold;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] req;
    logic               en;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] full;
    logic [NUM_REQ-1:0] drop;
    logic [NUM_REQ-1:0] starve;
    logic               proto_err;

    modport slave (
        input  push, hold, gnt,
        output req, en, done, full, drop, starve, proto_err
    );

    modport master (
        output push, hold, gnt,
        input  req, en, done, full, drop, starve, proto_err
    );

endinterface

// File: rtl/req_issuer4_chan.sv
// One request channel: pending-request counter, starvation wait counter and
// the registered done/drop/starve status for that channel.
module req_chan
    import req_issuer_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic push,
    input  logic en,
    input  logic gnt,
    input  logic valid_gnt,
    output logic req,
    output logic full,
    output logic done,
    output logic drop,
    output logic starve
);

    pend_t pend_q, pend_d;
    wait_t wait_q, wait_d;
    logic  done_q, drop_q, starve_q;
    logic  accept;

    always_comb begin
        full   = (pend_q == PEND_MAX);
        req    = (pend_q != '0);
        // A full channel still takes a push when a grant frees a slot this cycle.
        accept = push & (~full | valid_gnt);

        pend_d = pend_q;
        if (accept && !valid_gnt) begin
            pend_d = pend_q + pend_t'(1);
        end else if (valid_gnt && !accept) begin
            pend_d = pend_q - pend_t'(1);
        end

        wait_d = wait_q;
        if (valid_gnt || !req) begin
            wait_d = '0;
        end else if (en && !gnt && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + wait_t'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q   <= '0;
            wait_q   <= '0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
            starve_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            wait_q   <= wait_d;
            done_q   <= valid_gnt;
            drop_q   <= push & full & ~valid_gnt;
            starve_q <= valid_gnt ? 1'b0 : (starve_q | (wait_d == WAIT_MAX));
        end
    end

    assign done   = done_q;
    assign drop   = drop_q;
    assign starve = starve_q;

endmodule

// File: rtl/req_issuer4.sv
// Requester-side agent for the 4-way fixed-priority selector: buffers client
// requests, drives req/en, retires grants and flags starvation / bad grants.
module req_issuer4
    import req_issuer_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    req_issuer4_if.slave  bus
);

    logic               en_q;
    logic               proto_err_q;
    logic               gnt_ok;
    logic               gnt_bad;
    logic [NUM_REQ-1:0] valid_gnt;
    logic [NUM_REQ-1:0] req_v;
    logic [NUM_REQ-1:0] done_v;
    logic [NUM_REQ-1:0] full_v;
    logic [NUM_REQ-1:0] drop_v;
    logic [NUM_REQ-1:0] starve_v;

    // An all-zero gnt is simply "no grant"; only a non-zero gnt can be an error.
    always_comb begin
        gnt_ok    = en_q && at_most_one(bus.gnt) && ((bus.gnt & ~req_v) == '0);
        gnt_bad   = (bus.gnt != '0) && !gnt_ok;
        valid_gnt = gnt_ok ? bus.gnt : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en_q        <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            en_q        <= ~bus.hold;
            proto_err_q <= proto_err_q | gnt_bad;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_chan
        req_chan u_chan (
            .clock     (clock),
            .reset_n   (reset_n),
            .push      (bus.push[i]),
            .en        (en_q),
            .gnt       (bus.gnt[i]),
            .valid_gnt (valid_gnt[i]),
            .req       (req_v[i]),
            .full      (full_v[i]),
            .done      (done_v[i]),
            .drop      (drop_v[i]),
            .starve    (starve_v[i])
        );
    end

    assign bus.req       = req_v;
    assign bus.en        = en_q;
    assign bus.done      = done_v;
    assign bus.full      = full_v;
    assign bus.drop      = drop_v;
    assign bus.starve    = starve_v;
    assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_req_issuer4.sv
// Self-checking bench for req_issuer4: directed scenarios plus random pushes,
// compared every cycle against a counter-level reference model.
module tb_req_issuer4;
    import req_issuer_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    req_issuer4_if ifc ();

    req_issuer4 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    logic       force_on = 1'b0;
    logic [3:0] force_val = 4'b0000;

    // Fixed-priority selector: highest requesting index wins when enabled.
    function automatic logic [3:0] ps4(logic [3:0] r, logic e);
        if (!e) return 4'b0000;
        for (int i = 3; i >= 0; i--) begin
            if (r[i]) return 4'(1 << i);
        end
        return 4'b0000;
    endfunction

    always_comb ifc.gnt = force_on ? force_val : ps4(ifc.req, ifc.en);

    int         m_pend[4];
    int         m_wait[4];
    logic [3:0] m_done, m_drop, m_starve;
    logic       m_en, m_perr;
    int         n_vec = 0;
    int         n_err = 0;

    function automatic logic [3:0] m_req();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (m_pend[i] != 0);
        return r;
    endfunction

    function automatic logic [3:0] m_full();
        logic [3:0] f;
        for (int i = 0; i < 4; i++) f[i] = (m_pend[i] == 7);
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0;
            m_wait[i] = 0;
        end
        m_done = '0; m_drop = '0; m_starve = '0; m_en = 1'b0; m_perr = 1'b0;
    endtask

    task automatic model_step(logic [3:0] p, logic h);
        logic [3:0] r, g;
        logic       ok, gi;
        int         old;
        r  = m_req();
        g  = force_on ? force_val : ps4(r, m_en);
        ok = m_en && ($countones(g) <= 1) && ((g & ~r) == 4'b0000);
        if (g != 4'b0000 && !ok) m_perr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            gi  = ok && g[i];
            old = m_pend[i];
            m_done[i] = gi;
            m_drop[i] = 1'b0;
            if (p[i] && old == 7 && !gi) m_drop[i] = 1'b1;
            else if (p[i]) m_pend[i]++;
            if (gi) m_pend[i]--;
            if (old == 0 || gi) m_wait[i] = 0;
            else if (m_en && !g[i] && m_wait[i] < STARVE_LIM) m_wait[i]++;
            if (gi) m_starve[i] = 1'b0;
            else if (m_wait[i] == STARVE_LIM) m_starve[i] = 1'b1;
        end
        m_en = !h;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("req", 32'(ifc.req), 32'(m_req()));
        chk("en", 32'(ifc.en), 32'(m_en));
        chk("done", 32'(ifc.done), 32'(m_done));
        chk("full", 32'(ifc.full), 32'(m_full()));
        chk("drop", 32'(ifc.drop), 32'(m_drop));
        chk("starve", 32'(ifc.starve), 32'(m_starve));
        chk("proto_err", 32'(ifc.proto_err), 32'(m_perr));
    endtask

    // Called at a falling edge: apply inputs, advance model, check next falling edge.
    task automatic cycle(logic [3:0] p, logic h);
        ifc.push = p;
        ifc.hold = h;
        #1;
        model_step(p, h);
        @(negedge clock);
        check_all();
    endtask

    initial begin
        ifc.push = 4'b1111;
        ifc.hold = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check_all();
        chk("rst_req", 32'(ifc.req), 32'h0);

        // Release reset and check en loads after one edge
        reset_n = 1'b1;
        cycle(4'b0000, 1'b0);
        chk("en_after_release", 32'(ifc.en), 32'h1);

        // Priority drain
        cycle(4'b1001, 1'b0);
        chk("drain_req0", 32'(ifc.req), 32'h9);
        cycle(4'b0000, 1'b0);
        chk("drain_done1", 32'(ifc.done), 32'h8);
        chk("drain_req1", 32'(ifc.req), 32'h1);
        cycle(4'b0000, 1'b0);
        chk("drain_done2", 32'(ifc.done), 32'h1);
        chk("drain_req2", 32'(ifc.req), 32'h0);

        // Saturation with selector disabled
        cycle(4'b0000, 1'b1);
        repeat (8) cycle(4'b0010, 1'b1);
        chk("sat_full", 32'(ifc.full[1]), 32'h1);
        chk("sat_drop", 32'(ifc.drop[1]), 32'h1);
        cycle(4'b0000, 1'b0);
        repeat (8) cycle(4'b0000, 1'b0);
        chk("sat_req_empty", 32'(ifc.req[1]), 32'h0);
        chk("sat_not_full", 32'(ifc.full[1]), 32'h0);

        // Starvation of channel 0 behind channel 3
        cycle(4'b1001, 1'b0);
        repeat (10) cycle(4'b1000, 1'b0);
        chk("starve_set", 32'(ifc.starve[0]), 32'h1);
        chk("starve_req3", 32'(ifc.req[3]), 32'h1);
        repeat (3) cycle(4'b0000, 1'b0);
        chk("starve_clear", 32'(ifc.starve[0]), 32'h0);

        // Protocol error: two-hot grant while enabled
        force_on  = 1'b1;
        force_val = 4'b0000;
        cycle(4'b0000, 1'b1);
        cycle(4'b0110, 1'b1);
        cycle(4'b0000, 1'b0);
        force_val = 4'b0110;
        cycle(4'b0000, 1'b0);
        chk("perr_set", 32'(ifc.proto_err), 32'h1);
        chk("perr_req", 32'(ifc.req), 32'h6);
        chk("perr_done", 32'(ifc.done), 32'h0);
        force_val = 4'b0000;
        cycle(4'b0000, 1'b0);
        chk("perr_sticky", 32'(ifc.proto_err), 32'h1);
        force_on = 1'b0;
        repeat (4) cycle(4'b0000, 1'b0);

        // Random traffic with occasional holds
        for (int k = 0; k < 300; k++) begin
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
        end

        // Mid-operation reset with pending = {3,0,2,5}
        repeat (32) cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b1);
        repeat (2) cycle(4'b1011, 1'b1);
        cycle(4'b1001, 1'b1);
        repeat (2) cycle(4'b0001, 1'b1);
        chk("pre_rst_req", 32'(ifc.req), 32'hb);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_req", 32'(ifc.req), 32'h0);
        chk("midrst_done", 32'(ifc.done), 32'h0);
        chk("midrst_full", 32'(ifc.full), 32'h0);
        @(negedge clock);
        check_all();
        reset_n = 1'b1;
        repeat (10) begin
            cycle(4'b0000, 1'b0);
            chk("post_rst_done", 32'(ifc.done), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
